risc32_mem_access: RTL and testbench
====================================

# risc32_mem_access

Memory-access stage of the RISC32 pipeline, directly downstream of the execute stage. Consumes the execute outputs (ALU op, effective address, store data, write-back fields, HI/LO and CP0 write requests) and performs loads and stores over a single-master req/ack data bus. Aligns and sign-extends load data, produces the registered write-back bundle, and raises a pipeline stall while a bus transfer is outstanding.

## Interface
Parameters:
- none; widths come from the shared `Reg_Bus`, `Reg_Addr_Bus` and `Alu_Op_Bus` constants.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  exception/ERET flush; discards the in-stage instruction
- alu_op_i  in  Alu_Op_Bus  operation from execute
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store data, rt
- wd_i / wreg_i / wdata_i  in  5/1/32  GPR write-back from execute
- whilo_i / hi_i / lo_i  in  1/32/32  HI/LO write from execute
- cp0_reg_we_i / cp0_reg_write_addr_i / cp0_reg_data_i  in  1/5/32  CP0 write from execute
- wd_o / wreg_o / wdata_o  out  5/1/32  registered GPR write-back
- whilo_o / hi_o / lo_o  out  1/32/32  registered HI/LO write
- cp0_reg_we_o / cp0_reg_write_addr_o / cp0_reg_data_o  out  1/5/32  registered CP0 write
- exc_adel_o / exc_ades_o  out  1  registered address-error pulse, load/store
- stallreq_o  out  1  combinational stall request to the pipeline controller
- bus_req_o / bus_we_o  out  1/1  data-bus request and write flag
- bus_addr_o  out  32  word-aligned address, bits [1:0] = 0
- bus_sel_o  out  4  byte enables, big-endian
- bus_wdata_o  out  32  store data, replicated to byte lanes
- bus_rdata_i  in  32  read data, valid with ack
- bus_ack_i  in  1  transfer complete

## Operation
- FSM states: IDLE, BUS.
  - In IDLE, a legal memory op with flush_i = 0 registers the bus fields and moves to BUS.
  - In BUS, bus_ack_i = 1 returns the FSM to IDLE.
- Non-memory ops: the inputs are registered to the outputs unchanged. There is no bus activity.
- Load ops:
  - LB/LBU select the byte for addr[1:0]; 00 selects bits [31:24].
  - LH/LHU select the half for addr[1]; 0 selects bits [31:16].
  - LW returns the whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store ops:
  - SB: sel is 1000 >> addr[1:0], data is {4{rt[7:0]}}.
  - SH: sel is 1100 or 0011, data is {2{rt[15:0]}}.
  - SW: sel is 1111.
- Misalignment:
  - Affects LH/LHU/SH with addr[0] = 1, and LW/SW with addr[1:0] ≠ 0.
  - No bus request is issued.
  - exc_adel_o or exc_ades_o is set for one cycle and wreg_o = 0.
- Flush:
  - flush_i in IDLE: the next edge loads all outputs with zero/disabled values.
  - flush_i in BUS: the transfer still runs to ack and a store still commits. A discard flag forces wreg_o = 0 when the load result is registered.

## Timing
- Reset: all outputs are 0 and the FSM is in IDLE.
- Non-memory and misaligned ops: 1-cycle latency, stallreq_o = 0.
- Memory op presented in cycle T:
  - stallreq_o = 1 in T.
  - bus_req_o = 1 from T+1 until the ack cycle, inclusive.
  - bus_addr_o, bus_sel_o, bus_we_o and bus_wdata_o stay stable while bus_req_o = 1.
- Ack cycle:
  - stallreq_o = 0.
  - The write-back outputs register at the end of that cycle and the FSM returns to IDLE.
  - A zero-wait bus (ack in T+1) gives 2-cycle latency.
- Upstream holds its inputs stable while stallreq_o = 1.
- bus_ack_i is ignored when bus_req_o = 0.
- Asynchronous reset during BUS drops bus_req_o immediately.

## Configuration
RISC32_LLSC_EN compiles in LL/SC support.
- Defined: a 1-bit llbit register.
  - LL behaves as LW and sets llbit.
  - SC with llbit = 1 stores as SW, writes 1 to rt and clears llbit.
  - SC with llbit = 0 makes no bus access and writes 0 to rt with 1-cycle latency.
  - flush_i and reset clear llbit.
- Not defined: LL/SC ops make no bus access and force wreg_o = 0.

## Structure
- EXE_LB_OP through EXE_SC_OP opcodes belong in the shared instruction constants.
- The FSM state encodings are local to this block.
- Sub-module risc32_load_align (combinational) takes the raw word, addr[1:0] and the op, and returns the aligned, extended result.

## Test plan
- LB at addr 0x103 with rdata 0x1122_3380 and ack in T+1 -> wdata_o 0xFFFF_FF80, wreg_o 1, stallreq_o high for 1 cycle.
- SH at 0x202 with rt 0xABCD_1234 and ack after 3 wait cycles -> bus_sel_o 0011, bus_wdata_o 0x1234_1234, bus fields stable for 4 cycles.
- LW at 0x301 -> no bus_req_o, exc_adel_o pulse, wreg_o 0.
- ADDU result 0x55 passes through -> wdata_o 0x55 one cycle later, stallreq_o 0.
- LW in flight with flush_i in T+1 -> ack accepted, wreg_o 0, FSM in IDLE.
- RISC32_LLSC_EN: LL, then SC -> store issued and rt = 1; SC after a flush -> no bus access and rt = 0.

Source files
------------

// File: rtl/risc32_mem_access_pkg.sv
// Shared RISC32 constants: bus widths, execute-stage opcodes and
// small helpers for classifying and decoding memory operations.
package risc32_mem_access_pkg;

    localparam int Reg_Bus      = 32;
    localparam int Reg_Addr_Bus = 5;
    localparam int Alu_Op_Bus   = 8;

    typedef logic [Alu_Op_Bus-1:0] alu_op_t;

    localparam alu_op_t EXE_NOP_OP  = 8'b0000_0000;
    localparam alu_op_t EXE_ADDU_OP = 8'b0010_0001;
    localparam alu_op_t EXE_LB_OP   = 8'b1110_0000;
    localparam alu_op_t EXE_LH_OP   = 8'b1110_0001;
    localparam alu_op_t EXE_LW_OP   = 8'b1110_0011;
    localparam alu_op_t EXE_LBU_OP  = 8'b1110_0100;
    localparam alu_op_t EXE_LHU_OP  = 8'b1110_0101;
    localparam alu_op_t EXE_SB_OP   = 8'b1110_1000;
    localparam alu_op_t EXE_SH_OP   = 8'b1110_1001;
    localparam alu_op_t EXE_SW_OP   = 8'b1110_1011;
    localparam alu_op_t EXE_LL_OP   = 8'b1111_0000;
    localparam alu_op_t EXE_SC_OP   = 8'b1111_1000;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } mem_size_t;

    function automatic logic is_load(input alu_op_t op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store(input alu_op_t op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic mem_size_t mem_size(input alu_op_t op);
        mem_size_t sz;
        sz = SIZE_WORD;
        if ((op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_SB_OP))
            sz = SIZE_BYTE;
        else if ((op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP))
            sz = SIZE_HALF;
        return sz;
    endfunction

    function automatic logic misaligned(input mem_size_t sz, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (sz)
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'b00);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Big-endian lanes: byte address 0 lives in bits [31:24], i.e. sel[3].
    function automatic logic [3:0] byte_sel(input mem_size_t sz, input logic [1:0] off);
        logic [3:0] sel;
        sel = 4'b1111;
        case (sz)
            SIZE_BYTE: sel = 4'b1000 >> off;
            SIZE_HALF: sel = off[1] ? 4'b0011 : 4'b1100;
            default:   sel = 4'b1111;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/risc32_load_align.sv
// Load-data aligner: picks the addressed byte/half from a big-endian bus
// word and sign- or zero-extends it according to the load opcode.
module risc32_load_align
    import risc32_mem_access_pkg::*;
(
    input  logic [Reg_Bus-1:0] i_rdata,
    input  logic [1:0]         i_off,
    input  alu_op_t            i_op,
    output logic [Reg_Bus-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];

        o_data = i_rdata;
        case (i_op)
            EXE_LB_OP:  o_data = {{24{w_byte[7]}}, w_byte};
            EXE_LBU_OP: o_data = {24'h0, w_byte};
            EXE_LH_OP:  o_data = {{16{w_half[15]}}, w_half};
            EXE_LHU_OP: o_data = {16'h0, w_half};
            default:    o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/risc32_mem_access.sv
// RISC32 memory-access stage: req/ack data-bus loads and stores, address
// error detection, registered write-back. Define RISC32_LLSC_EN for LL/SC.
module risc32_mem_access
    import risc32_mem_access_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  alu_op_t                 alu_op_i,
    input  logic [Reg_Bus-1:0]      mem_addr_i,
    input  logic [Reg_Bus-1:0]      reg2_i,
    input  logic [Reg_Addr_Bus-1:0] wd_i,
    input  logic                    wreg_i,
    input  logic [Reg_Bus-1:0]      wdata_i,
    input  logic                    whilo_i,
    input  logic [Reg_Bus-1:0]      hi_i,
    input  logic [Reg_Bus-1:0]      lo_i,
    input  logic                    cp0_reg_we_i,
    input  logic [4:0]              cp0_reg_write_addr_i,
    input  logic [Reg_Bus-1:0]      cp0_reg_data_i,
    output logic [Reg_Addr_Bus-1:0] wd_o,
    output logic                    wreg_o,
    output logic [Reg_Bus-1:0]      wdata_o,
    output logic                    whilo_o,
    output logic [Reg_Bus-1:0]      hi_o,
    output logic [Reg_Bus-1:0]      lo_o,
    output logic                    cp0_reg_we_o,
    output logic [4:0]              cp0_reg_write_addr_o,
    output logic [Reg_Bus-1:0]      cp0_reg_data_o,
    output logic                    exc_adel_o,
    output logic                    exc_ades_o,
    output logic                    stallreq_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [Reg_Bus-1:0]      bus_addr_o,
    output logic [3:0]              bus_sel_o,
    output logic [Reg_Bus-1:0]      bus_wdata_o,
    input  logic [Reg_Bus-1:0]      bus_rdata_i,
    input  logic                    bus_ack_i
);

    typedef enum logic {
        IDLE,
        BUS
    } state_t;

    state_t                  r_state;
    alu_op_t                 r_op;
    logic [1:0]              r_off;
    logic [Reg_Addr_Bus-1:0] r_wd;
    logic                    r_wreg;
    logic                    r_load;
    logic                    r_discard;

    logic         w_ll, w_sc_go, w_sc_fail, w_llsc_off;
    logic         w_load, w_store, w_misal, w_go, w_ack;
    mem_size_t    w_size;
    logic [3:0]   w_sel;
    logic [31:0]  w_store_data;
    logic [31:0]  w_load_data;

    assign w_ack = (r_state == BUS) && bus_ack_i;

`ifdef RISC32_LLSC_EN
    logic r_llbit;

    assign w_ll       = (alu_op_i == EXE_LL_OP);
    assign w_sc_go    = (alu_op_i == EXE_SC_OP) && r_llbit;
    assign w_sc_fail  = (alu_op_i == EXE_SC_OP) && !r_llbit;
    assign w_llsc_off = 1'b0;

    // A discarded LL must not arm the link; a completed SC always consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_llbit <= 1'b0;
        end else if (flush_i) begin
            r_llbit <= 1'b0;
        end else if (w_ack) begin
            if (r_op == EXE_LL_OP && !r_discard)
                r_llbit <= 1'b1;
            else if (r_op == EXE_SC_OP)
                r_llbit <= 1'b0;
        end
    end
`else
    assign w_ll       = 1'b0;
    assign w_sc_go    = 1'b0;
    assign w_sc_fail  = 1'b0;
    assign w_llsc_off = (alu_op_i == EXE_LL_OP) || (alu_op_i == EXE_SC_OP);
`endif

    always_comb begin
        w_load  = is_load(alu_op_i) || w_ll;
        w_store = is_store(alu_op_i) || w_sc_go;
        w_size  = mem_size(alu_op_i);
        w_misal = (w_load || w_store) && misaligned(w_size, mem_addr_i[1:0]);
        w_go    = (w_load || w_store) && !w_misal;
        w_sel   = byte_sel(w_size, mem_addr_i[1:0]);
        case (w_size)
            SIZE_BYTE: w_store_data = {4{reg2_i[7:0]}};
            SIZE_HALF: w_store_data = {2{reg2_i[15:0]}};
            default:   w_store_data = reg2_i;
        endcase
    end

    assign stallreq_o = (r_state == IDLE) ? (w_go && !flush_i) : !bus_ack_i;

    risc32_load_align u_load_align (
        .i_rdata (bus_rdata_i),
        .i_off   (r_off),
        .i_op    (r_op),
        .o_data  (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state              <= IDLE;
            r_op                 <= EXE_NOP_OP;
            r_off                <= 2'b00;
            r_wd                 <= '0;
            r_wreg               <= 1'b0;
            r_load               <= 1'b0;
            r_discard            <= 1'b0;
            wd_o                 <= '0;
            wreg_o               <= 1'b0;
            wdata_o              <= '0;
            whilo_o              <= 1'b0;
            hi_o                 <= '0;
            lo_o                 <= '0;
            cp0_reg_we_o         <= 1'b0;
            cp0_reg_write_addr_o <= '0;
            cp0_reg_data_o       <= '0;
            exc_adel_o           <= 1'b0;
            exc_ades_o           <= 1'b0;
            bus_req_o            <= 1'b0;
            bus_we_o             <= 1'b0;
            bus_addr_o           <= '0;
            bus_sel_o            <= 4'b0000;
            bus_wdata_o          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    exc_adel_o <= 1'b0;
                    exc_ades_o <= 1'b0;
                    if (flush_i) begin
                        wd_o                 <= '0;
                        wreg_o               <= 1'b0;
                        wdata_o              <= '0;
                        whilo_o              <= 1'b0;
                        hi_o                 <= '0;
                        lo_o                 <= '0;
                        cp0_reg_we_o         <= 1'b0;
                        cp0_reg_write_addr_o <= '0;
                        cp0_reg_data_o       <= '0;
                    end else if (w_go) begin
                        // Emit a bubble downstream while the transfer is outstanding.
                        wd_o         <= '0;
                        wreg_o       <= 1'b0;
                        wdata_o      <= '0;
                        whilo_o      <= 1'b0;
                        cp0_reg_we_o <= 1'b0;
                        bus_req_o    <= 1'b1;
                        bus_we_o     <= w_store;
                        bus_addr_o   <= {mem_addr_i[31:2], 2'b00};
                        bus_sel_o    <= w_sel;
                        bus_wdata_o  <= w_store_data;
                        r_op         <= alu_op_i;
                        r_off        <= mem_addr_i[1:0];
                        r_wd         <= wd_i;
                        r_wreg       <= wreg_i;
                        r_load       <= w_load;
                        r_discard    <= 1'b0;
                        r_state      <= BUS;
                    end else begin
                        wd_o                 <= wd_i;
                        wreg_o               <= wreg_i && !w_misal && !w_llsc_off;
                        wdata_o              <= w_sc_fail ? '0 : wdata_i;
                        whilo_o              <= whilo_i;
                        hi_o                 <= hi_i;
                        lo_o                 <= lo_i;
                        cp0_reg_we_o         <= cp0_reg_we_i;
                        cp0_reg_write_addr_o <= cp0_reg_write_addr_i;
                        cp0_reg_data_o       <= cp0_reg_data_i;
                        exc_adel_o           <= w_misal && w_load;
                        exc_ades_o           <= w_misal && w_store;
                    end
                end
                BUS: begin
                    if (flush_i)
                        r_discard <= 1'b1;
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        wd_o      <= r_wd;
                        wreg_o    <= r_wreg && !r_discard && !flush_i;
                        wdata_o   <= r_load ? w_load_data : {31'h0, (r_op == EXE_SC_OP)};
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risc32_mem_access.sv
// Directed self-checking bench for risc32_mem_access; covers the LL/SC
// path when RISC32_LLSC_EN is defined, the disabled behaviour otherwise.
module tb_risc32_mem_access;
    import risc32_mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    alu_op_t     alu_op_i = EXE_NOP_OP;
    logic [31:0] mem_addr_i = '0, reg2_i = '0, wdata_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic        whilo_i = 1'b0;
    logic [31:0] hi_i = '0, lo_i = '0;
    logic        cp0_reg_we_i = 1'b0;
    logic [4:0]  cp0_reg_write_addr_i = '0;
    logic [31:0] cp0_reg_data_i = '0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        cp0_reg_we_o;
    logic [4:0]  cp0_reg_write_addr_o;
    logic [31:0] cp0_reg_data_o;
    logic        exc_adel_o, exc_ades_o, stallreq_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    risc32_mem_access dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .alu_op_i(alu_op_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
        .cp0_reg_we_i(cp0_reg_we_i), .cp0_reg_write_addr_i(cp0_reg_write_addr_i),
        .cp0_reg_data_i(cp0_reg_data_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .cp0_reg_we_o(cp0_reg_we_o), .cp0_reg_write_addr_o(cp0_reg_write_addr_o),
        .cp0_reg_data_o(cp0_reg_data_o),
        .exc_adel_o(exc_adel_o), .exc_ades_o(exc_ades_o), .stallreq_o(stallreq_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input alu_op_t op, input logic [31:0] addr, input logic [31:0] rt,
                                 input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        alu_op_i             = op;
        mem_addr_i           = addr;
        reg2_i               = rt;
        wd_i                 = wd;
        wreg_i               = wreg;
        wdata_i              = wdata;
        flush_i              = 1'b0;
        whilo_i              = 1'b0;
        hi_i                 = '0;
        lo_i                 = '0;
        cp0_reg_we_i         = 1'b0;
        cp0_reg_write_addr_i = '0;
        cp0_reg_data_i       = '0;
    endtask

    // Presents a legal memory op at a falling edge, acks after 'waits' idle
    // bus cycles and returns at the falling edge after the ack was taken.
    task automatic runMem(input alu_op_t op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [4:0] wd, input logic wreg, input int waits,
                          input logic [31:0] rdata, input logic [31:0] expAddr,
                          input logic [3:0] expSel, input logic expWe, input logic [31:0] expWdata);
        applyStimulus(op, addr, rt, wd, wreg, '0);
        #1 checkOutput("stall_first", stallreq_o, 1);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            checkOutput("bus_req", bus_req_o, 1);
            checkOutput("bus_addr", bus_addr_o, expAddr);
            checkOutput("bus_sel", bus_sel_o, expSel);
            checkOutput("bus_we", bus_we_o, expWe);
            if (expWe) checkOutput("bus_wdata", bus_wdata_o, expWdata);
            if (i == waits) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = rdata;
            end
            #1 checkOutput("stall_wait", stallreq_o, (i == waits) ? 0 : 1);
        end
        @(negedge clk);
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        applyStimulus(EXE_NOP_OP, '0, '0, '0, 1'b0, '0);
        checkOutput("bus_req_done", bus_req_o, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        checkOutput("rst_wreg", wreg_o, 0);
        checkOutput("rst_wdata", wdata_o, 0);
        checkOutput("rst_bus_req", bus_req_o, 0);
        checkOutput("rst_stall", stallreq_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDU passes through with HI/LO and CP0 fields
        applyStimulus(EXE_ADDU_OP, '0, '0, 5'd3, 1'b1, 32'h55);
        whilo_i = 1'b1; hi_i = 32'h1111_2222; lo_i = 32'h3333_4444;
        cp0_reg_we_i = 1'b1; cp0_reg_write_addr_i = 5'd12; cp0_reg_data_i = 32'hCAFE;
        #1 checkOutput("addu_stall", stallreq_o, 0);
        @(negedge clk);
        checkOutput("addu_wdata", wdata_o, 32'h55);
        checkOutput("addu_wreg", wreg_o, 1);
        checkOutput("addu_wd", wd_o, 3);
        checkOutput("addu_hi", hi_o, 32'h1111_2222);
        checkOutput("addu_lo", lo_o, 32'h3333_4444);
        checkOutput("addu_whilo", whilo_o, 1);
        checkOutput("addu_cp0_data", cp0_reg_data_o, 32'hCAFE);
        checkOutput("addu_cp0_addr", cp0_reg_write_addr_o, 12);
        checkOutput("addu_bus_req", bus_req_o, 0);

        // LB 0x103, zero-wait: byte 3 = 0x80 sign-extended
        runMem(EXE_LB_OP, 32'h103, '0, 5'd4, 1'b1, 0, 32'h1122_3380, 32'h100, 4'b0001, 1'b0, '0);
        checkOutput("lb_wdata", wdata_o, 32'hFFFF_FF80);
        checkOutput("lb_wreg", wreg_o, 1);
        checkOutput("lb_wd", wd_o, 4);

        // LBU 0x101: byte 1 = 0xA2 zero-extended
        runMem(EXE_LBU_OP, 32'h101, '0, 5'd9, 1'b1, 1, 32'h11A2_3344, 32'h100, 4'b0100, 1'b0, '0);
        checkOutput("lbu_wdata", wdata_o, 32'h0000_00A2);

        // LH 0x102: low half 0x8001 sign-extended
        runMem(EXE_LH_OP, 32'h102, '0, 5'd10, 1'b1, 0, 32'h1122_8001, 32'h100, 4'b0011, 1'b0, '0);
        checkOutput("lh_wdata", wdata_o, 32'hFFFF_8001);

        // LHU 0x100: high half 0x9ABC zero-extended
        runMem(EXE_LHU_OP, 32'h100, '0, 5'd11, 1'b1, 0, 32'h9ABC_0000, 32'h100, 4'b1100, 1'b0, '0);
        checkOutput("lhu_wdata", wdata_o, 32'h0000_9ABC);

        // SH 0x202, three wait cycles
        runMem(EXE_SH_OP, 32'h202, 32'hABCD_1234, 5'd0, 1'b0, 3, '0, 32'h200, 4'b0011, 1'b1, 32'h1234_1234);
        checkOutput("sh_wreg", wreg_o, 0);

        // SB 0x102 and SW 0x104
        runMem(EXE_SB_OP, 32'h102, 32'h0000_005A, 5'd0, 1'b0, 0, '0, 32'h100, 4'b0010, 1'b1, 32'h5A5A_5A5A);
        runMem(EXE_SW_OP, 32'h104, 32'hDEAD_BEEF, 5'd0, 1'b0, 0, '0, 32'h104, 4'b1111, 1'b1, 32'hDEAD_BEEF);

        // Misaligned LW: address-error pulse, no bus access
        applyStimulus(EXE_LW_OP, 32'h301, '0, 5'd5, 1'b1, '0);
        #1 checkOutput("lw_mis_stall", stallreq_o, 0);
        @(negedge clk);
        checkOutput("lw_mis_adel", exc_adel_o, 1);
        checkOutput("lw_mis_wreg", wreg_o, 0);
        checkOutput("lw_mis_bus_req", bus_req_o, 0);
        applyStimulus(EXE_NOP_OP, '0, '0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("lw_mis_adel_pulse", exc_adel_o, 0);

        // Misaligned SH: store address error
        applyStimulus(EXE_SH_OP, 32'h203, 32'h1, 5'd0, 1'b0, '0);
        @(negedge clk);
        checkOutput("sh_mis_ades", exc_ades_o, 1);
        checkOutput("sh_mis_adel", exc_adel_o, 0);
        checkOutput("sh_mis_bus_req", bus_req_o, 0);

        // LW in flight, flush in T+1, ack in T+2
        applyStimulus(EXE_LW_OP, 32'h400, '0, 5'd6, 1'b1, '0);
        @(negedge clk);
        checkOutput("flush_bus_req", bus_req_o, 1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h1234_5678;
        #1 checkOutput("flush_ack_stall", stallreq_o, 0);
        @(negedge clk);
        bus_ack_i = 1'b0;
        checkOutput("flush_wreg", wreg_o, 0);
        checkOutput("flush_bus_req_done", bus_req_o, 0);
        applyStimulus(EXE_ADDU_OP, '0, '0, 5'd7, 1'b1, 32'h77);
        #1 checkOutput("flush_idle_stall", stallreq_o, 0);
        @(negedge clk);
        checkOutput("flush_idle_wdata", wdata_o, 32'h77);

        // Flush in IDLE zeroes the outputs
        applyStimulus(EXE_ADDU_OP, '0, '0, 5'd8, 1'b1, 32'h99);
        flush_i = 1'b1;
        @(negedge clk);
        checkOutput("idle_flush_wreg", wreg_o, 0);
        checkOutput("idle_flush_wdata", wdata_o, 0);
        checkOutput("idle_flush_wd", wd_o, 0);

`ifdef RISC32_LLSC_EN
        runMem(EXE_LL_OP, 32'h500, '0, 5'd8, 1'b1, 0, 32'h1234_5678, 32'h500, 4'b1111, 1'b0, '0);
        checkOutput("ll_wdata", wdata_o, 32'h1234_5678);
        checkOutput("ll_wreg", wreg_o, 1);
        runMem(EXE_SC_OP, 32'h504, 32'h99, 5'd7, 1'b1, 0, '0, 32'h504, 4'b1111, 1'b1, 32'h99);
        checkOutput("sc_ok_wdata", wdata_o, 1);
        checkOutput("sc_ok_wreg", wreg_o, 1);
        checkOutput("sc_ok_wd", wd_o, 7);
        runMem(EXE_LL_OP, 32'h500, '0, 5'd8, 1'b1, 0, 32'h1, 32'h500, 4'b1111, 1'b0, '0);
        flush_i = 1'b1;
        @(negedge clk);
        applyStimulus(EXE_SC_OP, 32'h508, 32'h99, 5'd7, 1'b1, '0);
        #1 checkOutput("sc_fail_stall", stallreq_o, 0);
        @(negedge clk);
        checkOutput("sc_fail_bus_req", bus_req_o, 0);
        checkOutput("sc_fail_wdata", wdata_o, 0);
        checkOutput("sc_fail_wreg", wreg_o, 1);
`else
        applyStimulus(EXE_LL_OP, 32'h500, '0, 5'd8, 1'b1, 32'hAAAA);
        #1 checkOutput("ll_off_stall", stallreq_o, 0);
        @(negedge clk);
        checkOutput("ll_off_bus_req", bus_req_o, 0);
        checkOutput("ll_off_wreg", wreg_o, 0);
        applyStimulus(EXE_SC_OP, 32'h504, 32'h99, 5'd7, 1'b1, 32'hBBBB);
        #1 checkOutput("sc_off_stall", stallreq_o, 0);
        @(negedge clk);
        checkOutput("sc_off_bus_req", bus_req_o, 0);
        checkOutput("sc_off_wreg", wreg_o, 0);
`endif

        // Asynchronous reset during BUS drops the request immediately
        applyStimulus(EXE_LW_OP, 32'h600, '0, 5'd2, 1'b1, '0);
        @(negedge clk);
        checkOutput("rstbus_req_before", bus_req_o, 1);
        rst_n = 1'b0;
        #1 checkOutput("rstbus_req_dropped", bus_req_o, 0);
        applyStimulus(EXE_NOP_OP, '0, '0, '0, 1'b0, '0);
        #1 checkOutput("rstbus_stall", stallreq_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
